// File: rtl/alu16_seq.sv
// ---------------------------------------------------------------------------
// alu16_seq -- built-in self-test sequencer for a 16-bit ALU.
//
// Steps a fixed 13-entry vector table onto the ALU operand/opcode outputs,
// waits one settle cycle per vector, then folds the ALU result and flags into
// a 16-bit MISR. When all vectors are consumed it parks in DONE and flags
// pass when the signature matches golden_sig.
//
// Handshake: start is a level-sampled request with no ready/ack. It is only
// acted on in IDLE or DONE; while busy it is ignored. A run takes 26 edges
// after the start edge (2 per vector).
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high reset
//   start      - run request (sampled in IDLE/DONE only)
//   golden_sig - expected final signature (unregistered)
//   Y, N, Z, C - ALU result and negative/zero/carry flags
//   R, S       - registered ALU operands
//   Alu_Op     - registered ALU opcode (equals the vector index)
//   busy       - high in SETTLE and SAMPLE
//   done       - high in DONE
//   pass       - done AND signature == golden_sig (combinational)
//   signature  - running MISR value
//   count      - index of the current vector, 0..12
//   state_dbg  - current FSM state encoding for observation
// ---------------------------------------------------------------------------
module alu16_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] golden_sig,
  input  logic [15:0] Y,
  input  logic        N,
  input  logic        Z,
  input  logic        C,
  output logic [15:0] R,
  output logic [15:0] S,
  output logic [3:0]  Alu_Op,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [3:0]  count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0]  LAST_IDX = 4'd12;
  localparam logic [15:0] SIG_SEED = 16'hFFFF;

  state_t      state_q, state_d;
  logic [15:0] r_q, r_d;
  logic [15:0] s_q, s_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  count_q, count_d;
  logic [15:0] sig_q, sig_d;
  logic [3:0]  next_idx;
  logic [15:0] misr_next;

  // Vector table: {R, S}. Indices 13..15 are never selected.
  function automatic logic [31:0] vec_entry(input logic [3:0] k);
    case (k)
      4'd0:    vec_entry = {16'hAA55, 16'h55AA};
      4'd1:    vec_entry = {16'hCCCC, 16'h3333};
      4'd2:    vec_entry = {16'hC3C3, 16'h3C3C};
      4'd3:    vec_entry = {16'hB4B4, 16'h4B4B};
      4'd4:    vec_entry = {16'hD2D2, 16'h2D2D};
      4'd5:    vec_entry = {16'hE1E1, 16'h1E1E};
      4'd6:    vec_entry = {16'hF0F0, 16'h0F0F};
      4'd7:    vec_entry = {16'h1111, 16'hEEEE};
      4'd8:    vec_entry = {16'hBBBB, 16'h4444};
      4'd9:    vec_entry = {16'hAAAA, 16'h5555};
      4'd10:   vec_entry = {16'h4040, 16'h0404};
      4'd11:   vec_entry = {16'hF7F7, 16'hEFEF};
      4'd12:   vec_entry = {16'hABCD, 16'hDCBA};
      default: vec_entry = 32'h0;
    endcase
  endfunction

  assign next_idx = count_q + 4'd1;

  // Shift with feedback taps 15,14,12,3, then fold in the ALU result and flags.
  assign misr_next = {sig_q[14:0], sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3]}
                     ^ Y ^ {13'b0, N, Z, C};

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    s_d     = s_q;
    op_d    = op_q;
    count_d = count_q;
    sig_d   = sig_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          {r_d, s_d} = vec_entry(4'd0);
          op_d       = 4'd0;
          count_d    = 4'd0;
          sig_d      = SIG_SEED;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        state_d = SAMPLE;
      end
      SAMPLE: begin
        sig_d = misr_next;
        if (count_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          count_d    = next_idx;
          {r_d, s_d} = vec_entry(next_idx);
          op_d       = next_idx;
          state_d    = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= 16'h0;
      s_q     <= 16'h0;
      op_q    <= 4'h0;
      count_q <= 4'h0;
      sig_q   <= SIG_SEED;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      s_q     <= s_d;
      op_q    <= op_d;
      count_q <= count_d;
      sig_q   <= sig_d;
    end
  end

  assign R         = r_q;
  assign S         = s_q;
  assign Alu_Op    = op_q;
  assign count     = count_q;
  assign signature = sig_q;
  assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign pass      = done && (sig_q == golden_sig);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu16_seq.sv
// ---------------------------------------------------------------------------
// tb_alu16_seq -- self-checking bench for alu16_seq.
// A behavioural ALU drives Y/N/Z/C from the DUT operands. Expected operand
// vectors come from a local table; expected final signatures come from a
// bench MISR model and travel through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_alu16_seq;

  typedef struct {
    logic [15:0] r;
    logic [15:0] s;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] golden_sig;
  logic [15:0] Y;
  logic        N, Z, C;
  logic [15:0] R, S;
  logic [3:0]  Alu_Op;
  logic        busy, done, pass;
  logic [15:0] signature;
  logic [3:0]  count;
  logic [1:0]  state_dbg;

  bit          stuck_mode;
  vec_t        tab[13];
  logic [15:0] exp_q[$];
  logic [15:0] last_exp;
  int          n_vec;
  int          n_bad;

  alu16_seq dut (
    .clk(clk), .reset(reset), .start(start), .golden_sig(golden_sig),
    .Y(Y), .N(N), .Z(Z), .C(C),
    .R(R), .S(S), .Alu_Op(Alu_Op), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .count(count), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural ALU: returns {Y, N, Z, C} ----------------
  function automatic logic [18:0] alu(input logic [15:0] a, input logic [15:0] b,
                                      input logic [3:0] op);
    logic [16:0] w;
    logic [15:0] y;
    logic        c;
    w = 17'h0;
    c = 1'b0;
    case (op)
      4'd0:    begin w = {1'b0, a} + {1'b0, b}; y = w[15:0]; c = w[16]; end
      4'd1:    begin w = {1'b0, a} - {1'b0, b}; y = w[15:0]; c = w[16]; end
      4'd2:    y = a & b;
      4'd3:    y = a | b;
      4'd4:    y = a ^ b;
      4'd5:    y = ~a;
      4'd6:    begin y = {a[14:0], 1'b0}; c = a[15]; end
      4'd7:    begin y = {1'b0, a[15:1]}; c = a[0]; end
      4'd8:    begin w = {1'b0, a} + 17'd1; y = w[15:0]; c = w[16]; end
      4'd9:    begin w = {1'b0, a} - 17'd1; y = w[15:0]; c = w[16]; end
      4'd10:   y = b;
      4'd11:   y = ~(a ^ b);
      4'd12:   y = ~(a & b);
      default: y = a;
    endcase
    return {y, y[15], (y == 16'h0), c};
  endfunction

  always_comb begin
    {Y, N, Z, C} = 19'h0;
    if (!stuck_mode) {Y, N, Z, C} = alu(R, S, Alu_Op);
  end

  // ---------------- reference MISR model ----------------
  function automatic logic [15:0] model_sig(input bit stuck);
    logic [15:0] sg;
    logic [18:0] res;
    sg = 16'hFFFF;
    for (int k = 0; k < 13; k++) begin
      res = stuck ? 19'h0 : alu(tab[k].r, tab[k].s, 4'(k));
      sg  = {sg[14:0], sg[15] ^ sg[14] ^ sg[12] ^ sg[3]} ^ res[18:3] ^ {13'b0, res[2:0]};
    end
    return sg;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_R"}, R, 16'h0);
    check({tag, "_S"}, S, 16'h0);
    check({tag, "_op"}, 16'(Alu_Op), 16'h0);
    check({tag, "_count"}, 16'(count), 16'h0);
    check({tag, "_busy"}, 16'(busy), 16'h0);
    check({tag, "_done"}, 16'(done), 16'h0);
    check({tag, "_sig"}, signature, 16'hFFFF);
    check({tag, "_pass"}, 16'(pass), 16'h0);
    check({tag, "_state"}, 16'(state_dbg), 16'h0);
  endtask

  // Full run from IDLE or DONE; optionally re-asserts start at vector 5.
  task automatic run_full(input bit inject);
    exp_q.push_back(model_sig(stuck_mode));
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_sig_seed", signature, 16'hFFFF);
    check("start_done_low", 16'(done), 16'h0);
    for (int k = 0; k < 13; k++) begin
      check($sformatf("vec%0d_R", k), R, tab[k].r);
      check($sformatf("vec%0d_S", k), S, tab[k].s);
      check($sformatf("vec%0d_op", k), 16'(Alu_Op), 16'(k));
      check($sformatf("vec%0d_count", k), 16'(count), 16'(k));
      check($sformatf("vec%0d_busy", k), 16'(busy), 16'h1);
      if (inject && k == 5) start = 1'b1;
      step();
      start = 1'b0;
      check($sformatf("vec%0d_sample_busy", k), 16'(busy), 16'h1);
      check($sformatf("vec%0d_sample_done", k), 16'(done), 16'h0);
      check($sformatf("vec%0d_sample_R", k), R, tab[k].r);
      step();
    end
    check("end_done", 16'(done), 16'h1);
    check("end_busy", 16'(busy), 16'h0);
    check("end_count", 16'(count), 16'd12);
    check("end_R", R, tab[12].r);
    check("end_op", 16'(Alu_Op), 16'd12);
    check("end_state", 16'(state_dbg), 16'd3);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_empty: got no entry expected one");
    end else begin
      last_exp = exp_q.pop_front();
      check("end_signature", signature, last_exp);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_vec      = 0;
    n_bad      = 0;
    reset      = 1'b0;
    start      = 1'b0;
    golden_sig = 16'h0;
    stuck_mode = 1'b0;
    last_exp   = 16'h0;

    tab[0]  = '{16'hAA55, 16'h55AA};
    tab[1]  = '{16'hCCCC, 16'h3333};
    tab[2]  = '{16'hC3C3, 16'h3C3C};
    tab[3]  = '{16'hB4B4, 16'h4B4B};
    tab[4]  = '{16'hD2D2, 16'h2D2D};
    tab[5]  = '{16'hE1E1, 16'h1E1E};
    tab[6]  = '{16'hF0F0, 16'h0F0F};
    tab[7]  = '{16'h1111, 16'hEEEE};
    tab[8]  = '{16'hBBBB, 16'h4444};
    tab[9]  = '{16'hAAAA, 16'h5555};
    tab[10] = '{16'h4040, 16'h0404};
    tab[11] = '{16'hF7F7, 16'hEFEF};
    tab[12] = '{16'hABCD, 16'hDCBA};

    // Asynchronous reset before the first clock edge.
    #2 reset = 1'b1;
    #1 check_reset_vals("por");
    step();
    step();
    reset = 1'b0;
    step();
    check_reset_vals("idle_hold");

    // Normal run with the behavioural ALU.
    run_full(1'b0);
    golden_sig = last_exp;
    #1 check("pass_match", 16'(pass), 16'h1);
    golden_sig = last_exp ^ 16'h0100;
    #1 check("pass_flip", 16'(pass), 16'h0);
    golden_sig = last_exp;
    for (int i = 0; i < 3; i++) step();
    check("done_persist", 16'(done), 16'h1);
    check("sig_frozen", signature, last_exp);
    check("pass_persist", 16'(pass), 16'h1);

    // Restart from DONE, with a start re-assertion mid-run that must be ignored.
    run_full(1'b1);

    // Stuck ALU inputs: pure LFSR advance from FFFF.
    stuck_mode = 1'b1;
    run_full(1'b0);
    stuck_mode = 1'b0;

    // Abort mid-run with an asynchronous reset at count 7.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check("abort_count7", 16'(count), 16'd7);
    #2 reset = 1'b1;
    #1 check_reset_vals("abort");
    step();
    reset = 1'b0;
    step();
    check_reset_vals("post_abort");

    // A clean run after the aborted one.
    run_full(1'b0);
    golden_sig = last_exp;
    #1 check("pass_after_abort", 16'(pass), 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
